rot_shift_sequencer: RTL

- Multi-cycle sequencer for the 32-bit rotate/shift datapath used by the ALU for ROL, ROR, SHL, SHR and SHRA.
- Accepts one operation per valid/ready handshake and applies it in bounded steps of at most STEP positions per cycle, so a small per-cycle shifter replaces a full barrel rotator.
- Holds the result until the consumer (ALU result mux / Z register load) takes it.

---
 rtl/rot_shift_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rot_shift_sequencer.sv
// Multi-cycle rotate/shift sequencer: accepts one ROL/ROR/SHL/SHR/SHRA request,
// moves the operand at most STEP positions per cycle, then holds the result
// until the consumer takes it.
module rot_shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5,
    parameter int STEP  = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             busy
);

    // Step size needs to hold 0..STEP inclusive.
    localparam int K_W = $clog2(STEP + 1);

    localparam logic [2:0] OP_ROL  = 3'b000;
    localparam logic [2:0] OP_ROR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_SHRA = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [AMT_W-1:0] rem_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_err_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [K_W-1:0]   step_k_d;
    logic [WIDTH-1:0] work_d;
    logic [AMT_W-1:0] rem_d;

    // Apply one bounded step of the operation. SHRA keeps the MSB of the
    // working word, which is always the operand's original sign bit because
    // every earlier SHRA step preserved it.
    function automatic logic [WIDTH-1:0] apply_step(input logic [WIDTH-1:0] w,
                                                    input logic [2:0]       op,
                                                    input logic [K_W-1:0]   k);
        logic [2*WIDTH-1:0] dbl;
        logic [WIDTH-1:0]   res;
        dbl = '0;
        res = w;
        case (op)
            OP_ROL: begin
                dbl = {w, w} << k;
                res = dbl[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                dbl = {w, w} >> k;
                res = dbl[WIDTH-1:0];
            end
            OP_SHL:  res = w << k;
            OP_SHR:  res = w >> k;
            OP_SHRA: res = $signed(w) >>> k;
            default: res = w;
        endcase
        return res;
    endfunction

    // Step amount k = min(remaining, STEP) and the resulting next working word.
    always_comb begin
        step_k_d = '0;
        if ({1'b0, rem_q} > (AMT_W + 1)'(STEP)) begin
            step_k_d = K_W'(STEP);
        end else begin
            step_k_d = K_W'(rem_q);
        end
        work_d = apply_step(work_q, op_q, step_k_d);
        rem_d  = rem_q - AMT_W'(step_k_d);
    end

    // Control FSM with registered outputs; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q <= in_data;
                        rem_q  <= in_amt;
                        op_q   <= in_op;
                        if (in_op > OP_SHRA) begin
                            out_data_q  <= in_data;
                            out_err_q   <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else if (in_amt == '0) begin
                            out_data_q  <= in_data;
                            out_err_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        out_data_q  <= work_d;
                        out_err_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = clr_n && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign busy      = busy_q;

endmodule
